deadtime_gate_driver: RTL and testbench

//   Downstream stage of the complementary PWM generator. Consumes fsw/fsw_bar and drives the

---
 rtl/pwm_pkg.sv | 27 ++
 rtl/dt_timer.sv | 37 +++
 rtl/deadtime_gate_driver.sv | 101 ++++++++++
 tb/tb_deadtime_gate_driver.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared encodings for the complementary PWM path: FSM states, decoded command
// values and the default dead-time counter width.
package pwm_pkg;

   localparam int DT_WIDTH_DEFAULT = 7;

   localparam logic [2:0] OFF   = 3'd0;
   localparam logic [2:0] DT_HI = 3'd1;
   localparam logic [2:0] DT_LO = 3'd2;
   localparam logic [2:0] ON_HI = 3'd3;
   localparam logic [2:0] ON_LO = 3'd4;
   localparam logic [2:0] FAULT = 3'd5;

   localparam logic [1:0] CMD_OFF = 2'd0;
   localparam logic [1:0] CMD_HI  = 2'd1;
   localparam logic [1:0] CMD_LO  = 2'd2;

   // Overlapping (11) and idle (00) PWM commands both mean "no gate on".
   function automatic logic [1:0] decode_cmd(input logic hi, input logic lo);
      case ({hi, lo})
         2'b10:   decode_cmd = CMD_HI;
         2'b01:   decode_cmd = CMD_LO;
         default: decode_cmd = CMD_OFF;
      endcase
   endfunction

endpackage

// File: rtl/dt_timer.sv
// Dead-time interval counter: load clears it, enable advances it, and it parks
// at DEAD_TIME-1 (done) until the parent leaves the dead-time state.
module dt_timer #(
   parameter int DT_WIDTH  = 7,
   parameter int DEAD_TIME = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic en,
   output logic done
);

   localparam logic [DT_WIDTH-1:0] LAST = DT_WIDTH'(DEAD_TIME - 1);

   logic [DT_WIDTH-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = '0;
      end else if (en && (count_q != LAST)) begin
         count_d = count_q + DT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign done = (count_q == LAST);

endmodule

// File: rtl/deadtime_gate_driver.sv
// Half-bridge gate driver: inserts a programmable dead time before either gate
// turns on, never overlaps the gates, and latches external faults to all-off.
module deadtime_gate_driver
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH  = DT_WIDTH_DEFAULT,
   parameter int DEAD_TIME = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic fsw,
   input  logic fsw_bar,
   input  logic fault,
   input  logic fault_clr,
   output logic gate_hi,
   output logic gate_lo,
   output logic dt_active,
   output logic fault_lat
);

   logic [2:0] state_q, state_d;
   logic [1:0] cmd_q;
   logic       dt_load, dt_inc, dt_done;
   logic       gate_hi_q, gate_lo_q, dt_active_q, fault_lat_q;

   dt_timer #(
      .DT_WIDTH  (DT_WIDTH),
      .DEAD_TIME (DEAD_TIME)
   ) u_dt_timer (
      .clk   (clk),
      .reset (reset),
      .load  (dt_load),
      .en    (dt_inc),
      .done  (dt_done)
   );

   always_comb begin
      state_d = state_q;
      dt_load = 1'b0;
      dt_inc  = 1'b0;
      if (fault) begin
         state_d = FAULT;
      end else if (state_q == FAULT) begin
         if (fault_clr) state_d = OFF;
      end else if (!en) begin
         state_d = OFF;
      end else if (cmd_q == CMD_HI) begin
         // Any non-HI state restarts a full dead interval toward the high side.
         case (state_q)
            DT_HI: begin
               if (dt_done) state_d = ON_HI;
               else         dt_inc  = 1'b1;
            end
            ON_HI: state_d = ON_HI;
            default: begin
               state_d = DT_HI;
               dt_load = 1'b1;
            end
         endcase
      end else if (cmd_q == CMD_LO) begin
         case (state_q)
            DT_LO: begin
               if (dt_done) state_d = ON_LO;
               else         dt_inc  = 1'b1;
            end
            ON_LO: state_d = ON_LO;
            default: begin
               state_d = DT_LO;
               dt_load = 1'b1;
            end
         endcase
      end else begin
         state_d = OFF;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= OFF;
         cmd_q       <= CMD_OFF;
         gate_hi_q   <= 1'b0;
         gate_lo_q   <= 1'b0;
         dt_active_q <= 1'b0;
         fault_lat_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_q       <= decode_cmd(fsw, fsw_bar);
         gate_hi_q   <= (state_d == ON_HI);
         gate_lo_q   <= (state_d == ON_LO);
         dt_active_q <= (state_d == DT_HI) || (state_d == DT_LO);
         fault_lat_q <= (state_d == FAULT);
      end
   end

   assign gate_hi   = gate_hi_q;
   assign gate_lo   = gate_lo_q;
   assign dt_active = dt_active_q;
   assign fault_lat = fault_lat_q;

endmodule

// File: tb/tb_deadtime_gate_driver.sv
// Directed bench for deadtime_gate_driver with DEAD_TIME=5, followed by a
// randomized stress phase checking the gate-safety invariants every cycle.
module tb_deadtime_gate_driver;

   localparam int DT = 5;

   // Output vectors packed as {gate_hi, gate_lo, dt_active, fault_lat}.
   localparam logic [3:0] V_OFF = 4'b0000;
   localparam logic [3:0] V_DT  = 4'b0010;
   localparam logic [3:0] V_HI  = 4'b1000;
   localparam logic [3:0] V_LO  = 4'b0100;
   localparam logic [3:0] V_FLT = 4'b0001;

   logic clk = 1'b0;
   logic reset, en, fsw, fsw_bar, fault, fault_clr;
   logic gate_hi, gate_lo, dt_active, fault_lat;

   int checks = 0;
   int errors = 0;
   int low_run = 0;
   logic prev_hi = 1'b0;
   logic prev_lo = 1'b0;

   always #5 clk = ~clk;

   deadtime_gate_driver #(
      .DT_WIDTH  (7),
      .DEAD_TIME (DT)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .en        (en),
      .fsw       (fsw),
      .fsw_bar   (fsw_bar),
      .fault     (fault),
      .fault_clr (fault_clr),
      .gate_hi   (gate_hi),
      .gate_lo   (gate_lo),
      .dt_active (dt_active),
      .fault_lat (fault_lat)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One clock: sample #1 after the rising edge and check safety invariants.
   task automatic tick();
      @(posedge clk);
      #1;
      chk("no_overlap", {3'b000, gate_hi & gate_lo}, 4'b0000);
      chk("dt_gates_low", {3'b000, dt_active & (gate_hi | gate_lo)}, 4'b0000);
      if ((gate_hi && !prev_hi) || (gate_lo && !prev_lo))
         chk("rise_after_dead", {3'b000, low_run >= DT}, 4'b0001);
      low_run = (!gate_hi && !gate_lo) ? low_run + 1 : 0;
      prev_hi = gate_hi;
      prev_lo = gate_lo;
   endtask

   task automatic expect_for(input int n, input logic [3:0] vec, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk(tag, {gate_hi, gate_lo, dt_active, fault_lat}, vec);
      end
   endtask

   task automatic drive_cmd(input logic hi, input logic lo);
      fsw     = hi;
      fsw_bar = lo;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; fault = 1'b0; fault_clr = 1'b0;
      drive_cmd(1'b1, 1'b0);

      // Reset held three cycles with fsw=1.
      expect_for(3, V_OFF, "reset");
      reset = 1'b0;
      expect_for(1, V_OFF, "post_reset_off");
      expect_for(DT, V_DT, "first_dt_hi");
      expect_for(2, V_HI, "first_on_hi");

      // HI -> LO: old gate drops next edge, new gate after DT dead cycles.
      drive_cmd(1'b0, 1'b1);
      expect_for(1, V_HI, "hl_sample_edge");
      expect_for(DT, V_DT, "hl_dead");
      expect_for(2, V_LO, "hl_on_lo");

      // Retarget: LO -> HI, then back to LO two cycles into the dead time.
      drive_cmd(1'b1, 1'b0);
      expect_for(1, V_LO, "rt_sample_edge");
      expect_for(2, V_DT, "rt_dead_hi");
      drive_cmd(1'b0, 1'b1);
      expect_for(1 + DT, V_DT, "rt_dead_restart");
      expect_for(2, V_LO, "rt_on_lo");

      // Back to HI, then the invalid 11 command.
      drive_cmd(1'b1, 1'b0);
      expect_for(1, V_LO, "lh_sample_edge");
      expect_for(DT, V_DT, "lh_dead");
      expect_for(1, V_HI, "lh_on_hi");
      drive_cmd(1'b1, 1'b1);
      expect_for(1, V_HI, "inv_sample_edge");
      expect_for(2, V_OFF, "inv_off");
      drive_cmd(1'b1, 1'b0);
      expect_for(1, V_OFF, "inv_resume_sample");
      expect_for(DT, V_DT, "inv_resume_dead");
      expect_for(1, V_HI, "inv_resume_on_hi");

      // Fault while ON_LO.
      drive_cmd(1'b0, 1'b1);
      expect_for(1, V_HI, "pre_fault_sample");
      expect_for(DT, V_DT, "pre_fault_dead");
      expect_for(1, V_LO, "pre_fault_on_lo");
      fault = 1'b1;
      expect_for(1, V_FLT, "fault_entry");
      fault_clr = 1'b1;
      expect_for(2, V_FLT, "clr_ignored_during_fault");
      fault = 1'b0; fault_clr = 1'b0;
      expect_for(2, V_FLT, "fault_latched");
      fault_clr = 1'b1;
      expect_for(1, V_OFF, "fault_cleared");
      fault_clr = 1'b0;
      expect_for(DT, V_DT, "post_fault_dead");
      expect_for(1, V_LO, "post_fault_on_lo");

      // en=0 in the middle of a dead interval.
      drive_cmd(1'b1, 1'b0);
      expect_for(1, V_LO, "en_sample_edge");
      expect_for(2, V_DT, "en_partial_dead");
      en = 1'b0;
      expect_for(2, V_OFF, "en_low_off");
      en = 1'b1;
      expect_for(DT, V_DT, "en_full_dead");
      expect_for(1, V_HI, "en_on_hi");

      // Reset clears a latched fault.
      fault = 1'b1;
      expect_for(1, V_FLT, "fault_before_reset");
      fault = 1'b0;
      reset = 1'b1;
      expect_for(1, V_OFF, "reset_clears_fault");
      reset = 1'b0;

      // Random stress: inputs held for random stretches.
      for (int i = 0; i < 400; i++) begin
         fsw       = 1'($urandom_range(0, 1));
         fsw_bar   = 1'($urandom_range(0, 1));
         en        = ($urandom_range(0, 7) != 0);
         fault     = ($urandom_range(0, 15) == 0);
         fault_clr = 1'($urandom_range(0, 1));
         for (int j = 0; j < int'($urandom_range(1, 10)); j++) tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
